imm_split: RTL and testbench

Constant splitter: the inverse of the immediate extender. It accepts a 32-bit constant and emits the shortest sequence of 20-bit immediate words that, once expanded by the extender's ext_op/unsigned_op modes, reconstructs the constant exactly. Each word is one beat; a constant produces either one beat or an upper/lower pair. The block sits in the instruction-generation path, ahead of the immediate extender, and uses valid/ready handshakes on both sides.

---
 rtl/imm_split.sv | 171 +++++++++++++++++
 tb/tb_imm_split.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/imm_split.sv
// imm_split: breaks a 32-bit constant into the shortest sequence of 20-bit
// immediate words (one word, or an upper/lower pair) for the immediate extender.
module imm_split (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    input  logic [31:0] in_value_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [19:0] out_imm_o,
    output logic        out_ext_op_o,
    output logic        out_unsigned_op_o,
    output logic        out_upper_o,
    output logic        out_last_o
);

    localparam int unsigned IMM_W = 20;
    localparam int unsigned LO_W  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        HI   = 2'd2,
        LO   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IMM_W-1:0]   imm_q, imm_d;
    logic               ext_q, ext_d;
    logic               uns_q, uns_d;
    logic               upper_q, upper_d;
    logic               last_q, last_d;
    logic [LO_W-1:0]    lo_q, lo_d;

    logic               hs;
    logic               accept;
    logic               load;

    logic               cls_pair;
    logic [IMM_W-1:0]   cls_imm;
    logic               cls_ext;
    logic               cls_uns;
    logic               cls_upper;
    logic               cls_last;

    logic               is_s12;
    logic               is_u12;
    logic               is_s20;
    logic [IMM_W-1:0]   hi_rounded;

    // Handshake decode; a new constant can enter while the last word leaves
    always_comb begin
        out_valid_o = (state_q != IDLE);
        hs          = out_valid_o & out_ready_i;
        in_ready_o  = (state_q == IDLE) | (hs & last_q);
        accept      = in_valid_i & in_ready_o;
    end

    // Classify the incoming constant and form its first word
    always_comb begin
        is_s12     = (&in_value_i[31:11]) | ~(|in_value_i[31:11]);
        is_u12     = ~(|in_value_i[31:12]);
        is_s20     = (&in_value_i[31:19]) | ~(|in_value_i[31:19]);
        hi_rounded = in_value_i[31:12] + IMM_W'(in_value_i[11]);

        cls_pair  = 1'b0;
        cls_imm   = {8'h00, in_value_i[11:0]};
        cls_ext   = 1'b0;
        cls_uns   = 1'b0;
        cls_upper = 1'b0;
        cls_last  = 1'b1;

        if (is_s12) begin
            cls_uns = 1'b0;
        end else if (is_u12) begin
            cls_uns = 1'b1;
        end else if (is_s20) begin
            cls_imm = in_value_i[19:0];
            cls_ext = 1'b1;
        end else begin
            // Upper half is rounded so the sign-extended low word lands exactly
            cls_pair  = 1'b1;
            cls_imm   = hi_rounded;
            cls_ext   = 1'b1;
            cls_upper = 1'b1;
            cls_last  = 1'b0;
        end
    end

    // Next-state and output-field logic
    always_comb begin
        state_d = state_q;
        imm_d   = imm_q;
        ext_d   = ext_q;
        uns_d   = uns_q;
        upper_d = upper_q;
        last_d  = last_q;
        lo_d    = lo_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                load = accept;
            end
            ONE, LO: begin
                if (hs) begin
                    if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HI: begin
                if (hs) begin
                    state_d = LO;
                    imm_d   = {8'h00, lo_q};
                    ext_d   = 1'b0;
                    uns_d   = 1'b0;
                    upper_d = 1'b0;
                    last_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d = cls_pair ? HI : ONE;
            imm_d   = cls_imm;
            ext_d   = cls_ext;
            uns_d   = cls_uns;
            upper_d = cls_upper;
            last_d  = cls_last;
            lo_d    = in_value_i[11:0];
        end
    end

    // State and output registers; reset drops any pending constant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            imm_q   <= '0;
            ext_q   <= 1'b0;
            uns_q   <= 1'b0;
            upper_q <= 1'b0;
            last_q  <= 1'b0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            imm_q   <= imm_d;
            ext_q   <= ext_d;
            uns_q   <= uns_d;
            upper_q <= upper_d;
            last_q  <= last_d;
            lo_q    <= lo_d;
        end
    end

    // Output fields straight from their registers
    always_comb begin
        out_imm_o         = imm_q;
        out_ext_op_o      = ext_q;
        out_unsigned_op_o = uns_q;
        out_upper_o       = upper_q;
        out_last_o        = last_q;
    end

endmodule

// File: tb/tb_imm_split.sv
// Directed bench for imm_split: vector table plus streaming, backpressure and reset sequences.
module tb_imm_split;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_value;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_imm;
    logic        out_ext_op;
    logic        out_unsigned_op;
    logic        out_upper;
    logic        out_last;

    int tests;
    int fails;

    typedef struct {
        logic [31:0] value;
        logic        pair;
        logic [19:0] imm0;
        logic        ext0;
        logic        uns0;
        logic [19:0] imm1;
    } vec_t;

    vec_t vecs[10];

    imm_split dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid_i        (in_valid),
        .in_value_i        (in_value),
        .in_ready_o        (in_ready),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .out_imm_o         (out_imm),
        .out_ext_op_o      (out_ext_op),
        .out_unsigned_op_o (out_unsigned_op),
        .out_upper_o       (out_upper),
        .out_last_o        (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] recon(input logic [19:0] hi, input logic [19:0] lo);
        recon = {hi[19:0], 12'h000} + {{20{lo[11]}}, lo[11:0]};
    endfunction

    task automatic check_word(input string tag, input logic [19:0] imm, input logic ext,
                              input logic uns, input logic upper, input logic last);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".imm"},   32'(out_imm),   32'(imm));
        check({tag, ".ext"},   32'(out_ext_op), 32'(ext));
        if (!ext) check({tag, ".uns"}, 32'(out_unsigned_op), 32'(uns));
        check({tag, ".upper"}, 32'(out_upper), 32'(upper));
        check({tag, ".last"},  32'(out_last),  32'(last));
    endtask

    initial begin
        logic [19:0] hi_seen;
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_value  = '0;
        out_ready = 1'b1;

        //            value          pair  imm0      ext  uns  imm1
        vecs[0] = '{32'h0000_0001, 1'b0, 20'h00001, 1'b0, 1'b0, 20'h0};
        vecs[1] = '{32'hFFFF_F800, 1'b0, 20'h00800, 1'b0, 1'b0, 20'h0};
        vecs[2] = '{32'h0000_0FFF, 1'b0, 20'h00FFF, 1'b0, 1'b1, 20'h0};
        vecs[3] = '{32'h0007_FFFF, 1'b0, 20'h7FFFF, 1'b1, 1'b0, 20'h0};
        vecs[4] = '{32'hFFF8_0000, 1'b0, 20'h80000, 1'b1, 1'b0, 20'h0};
        vecs[5] = '{32'h0008_0000, 1'b1, 20'h00080, 1'b1, 1'b0, 20'h00000};
        vecs[6] = '{32'h1234_5FFF, 1'b1, 20'h12346, 1'b1, 1'b0, 20'h00FFF};
        vecs[7] = '{32'h7FFF_F800, 1'b1, 20'h80000, 1'b1, 1'b0, 20'h00800};
        vecs[8] = '{32'hFFFF_FFFF, 1'b0, 20'h00FFF, 1'b0, 1'b0, 20'h0};
        vecs[9] = '{32'h0000_0800, 1'b0, 20'h00800, 1'b0, 1'b1, 20'h0};

        // Reset state
        #12;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.imm",   32'(out_imm),   32'd0);
        check("rst.last",  32'(out_last),  32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table, out_ready held high
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_value = vecs[i].value;
            check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            if (vecs[i].pair) begin
                check_word($sformatf("v%0d.w0", i), vecs[i].imm0, 1'b1, 1'b0, 1'b1, 1'b0);
                check($sformatf("v%0d.hi_in_ready", i), 32'(in_ready), 32'd0);
                hi_seen = out_imm;
                @(negedge clk);
                check_word($sformatf("v%0d.w1", i), vecs[i].imm1, 1'b0, 1'b0, 1'b0, 1'b1);
                check($sformatf("v%0d.recon", i), recon(hi_seen, out_imm), vecs[i].value);
            end else begin
                check_word($sformatf("v%0d.w0", i), vecs[i].imm0, vecs[i].ext0, vecs[i].uns0,
                           1'b0, 1'b1);
            end
            @(negedge clk);
            check($sformatf("v%0d.idle", i), 32'(out_valid), 32'd0);
        end

        // Back-to-back stream: 0x5, 0x12345FFF, 0x7
        in_valid = 1'b1;
        in_value = 32'h5;
        @(negedge clk);
        check_word("b2b.5", 20'h00005, 1'b0, 1'b0, 1'b0, 1'b1);
        check("b2b.5.in_ready", 32'(in_ready), 32'd1);
        in_value = 32'h1234_5FFF;
        @(negedge clk);
        check_word("b2b.hi", 20'h12346, 1'b1, 1'b0, 1'b1, 1'b0);
        check("b2b.hi.in_ready", 32'(in_ready), 32'd0);
        in_value = 32'h7;
        @(negedge clk);
        check_word("b2b.lo", 20'h00FFF, 1'b0, 1'b0, 1'b0, 1'b1);
        check("b2b.lo.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_word("b2b.7", 20'h00007, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("b2b.idle", 32'(out_valid), 32'd0);

        // Backpressure in HI for three cycles
        in_valid  = 1'b1;
        in_value  = 32'h1234_5FFF;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d.imm", k), 32'(out_imm), 32'h12346);
            check($sformatf("bp%0d.upper", k), 32'(out_upper), 32'd1);
            check($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'd0);
            if (k == 2) out_ready = 1'b1;
            @(negedge clk);
        end
        check_word("bp.lo", 20'h00FFF, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("bp.idle", 32'(out_valid), 32'd0);

        // Reset while in LO
        in_valid = 1'b1;
        in_value = 32'h1234_5FFF;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("rlo.imm_before", 32'(out_imm), 32'h00FFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("rlo.valid",  32'(out_valid),  32'd0);
        check("rlo.imm",    32'(out_imm),    32'd0);
        check("rlo.ext",    32'(out_ext_op), 32'd0);
        check("rlo.uns",    32'(out_unsigned_op), 32'd0);
        check("rlo.upper",  32'(out_upper),  32'd0);
        check("rlo.last",   32'(out_last),   32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rlo.no_residual", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_value = 32'h1;
        @(negedge clk);
        in_valid = 1'b0;
        check_word("rlo.one", 20'h00001, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("rlo.idle", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
